// File: rtl/sccb_responder.sv
// SCCB responder: camera-side emulation of the configuration bus with a 256x8 register file.
// Optional read transfers are enabled by defining SCCB_READ_EN.
module sccb_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] host_addr,
    output logic [7:0] host_dout
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_DATA,
        ST_DATA_ACK,
`ifdef SCCB_READ_EN
        ST_RD,
        ST_RD_ACK,
`endif
        ST_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] sioc_sync_r;
    logic [SYNC_STAGES-1:0] siod_sync_r;
    logic                   c_prev_r;
    logic                   d_prev_r;
    state_t                 state_r;
    logic [2:0]             cnt_r;
    logic [7:0]             shift_r;
    logic [7:0]             ptr_r;
    logic [7:0]             regs_r [256];
`ifdef SCCB_READ_EN
    logic                   rd_sel_r;
`endif

    logic       c_s;
    logic       d_s;
    logic       c_rise_s;
    logic       c_fall_s;
    logic       start_s;
    logic       stop_s;
    logic       rx_state_s;
    logic       byte_done_s;
    logic [7:0] byte_s;
    logic       id_match_s;

    assign c_s         = sioc_sync_r[SYNC_STAGES-1];
    assign d_s         = siod_sync_r[SYNC_STAGES-1];
    assign c_rise_s    = c_s & ~c_prev_r;
    assign c_fall_s    = ~c_s & c_prev_r;
    assign start_s     = c_s & d_prev_r & ~d_s;
    assign stop_s      = c_s & ~d_prev_r & d_s;
    assign byte_s      = {shift_r[6:0], d_s};
    assign id_match_s  = (byte_s[7:1] == DEVICE_ID[7:1]);
    assign byte_done_s = c_rise_s & rx_state_s & (cnt_r == 3'd7);
`ifdef SCCB_READ_EN
    assign rx_state_s  = (state_r == ST_ID) | (state_r == ST_SUB) | (state_r == ST_DATA) |
                         (state_r == ST_RD);
`else
    assign rx_state_s  = (state_r == ST_ID) | (state_r == ST_SUB) | (state_r == ST_DATA);
`endif

    // Line synchronizers; idle bus level is high so reset to 1 to avoid false edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_sync_r <= '1;
            siod_sync_r <= '1;
            c_prev_r    <= 1'b1;
            d_prev_r    <= 1'b1;
        end else begin
            sioc_sync_r <= {sioc_sync_r[SYNC_STAGES-2:0], sioc};
            siod_sync_r <= {siod_sync_r[SYNC_STAGES-2:0], siod_in};
            c_prev_r    <= c_s;
            d_prev_r    <= d_s;
        end
    end

    // Protocol FSM, register file writes and SIOD drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            shift_r <= 8'h00;
            ptr_r   <= 8'h00;
            siod_oe <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            busy    <= 1'b0;
`ifdef SCCB_READ_EN
            rd_sel_r <= 1'b0;
`endif
            for (int i = 0; i < 256; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            wr_stb <= 1'b0;
            if (stop_s) begin
                state_r <= ST_IDLE;
                cnt_r   <= 3'd0;
                siod_oe <= 1'b0;
                busy    <= 1'b0;
            end else if (start_s) begin
                state_r <= ST_ID;
                cnt_r   <= 3'd0;
                siod_oe <= 1'b0;
                busy    <= 1'b1;
            end else begin
                if (c_rise_s && rx_state_s) begin
                    shift_r <= byte_s;
                    cnt_r   <= cnt_r + 3'd1;
                end
                case (state_r)
                    ST_IDLE: begin
                        siod_oe <= 1'b0;
                    end
                    ST_ID: begin
                        if (byte_done_s) begin
                            if (id_match_s && !byte_s[0]) begin
                                state_r <= ST_ID_ACK;
`ifdef SCCB_READ_EN
                                rd_sel_r <= 1'b0;
                            end else if (id_match_s) begin
                                state_r  <= ST_ID_ACK;
                                rd_sel_r <= 1'b1;
`endif
                            end else begin
                                state_r <= ST_WAIT_STOP;
                            end
                        end
                    end
                    // Ack slot: first c fall pulls SIOD low, the next one releases it.
                    ST_ID_ACK: begin
                        if (c_fall_s) begin
                            if (!siod_oe) begin
                                siod_oe <= 1'b1;
                            end else begin
`ifdef SCCB_READ_EN
                                if (rd_sel_r) begin
                                    state_r <= ST_RD;
                                    siod_oe <= ~regs_r[ptr_r][7];
                                end else begin
                                    state_r <= ST_SUB;
                                    siod_oe <= 1'b0;
                                end
`else
                                state_r <= ST_SUB;
                                siod_oe <= 1'b0;
`endif
                            end
                        end
                    end
                    ST_SUB: begin
                        if (byte_done_s) begin
                            ptr_r   <= byte_s;
                            state_r <= ST_SUB_ACK;
                        end
                    end
                    ST_SUB_ACK, ST_DATA_ACK: begin
                        if (c_fall_s) begin
                            if (!siod_oe) begin
                                siod_oe <= 1'b1;
                            end else begin
                                siod_oe <= 1'b0;
                                state_r <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (byte_done_s) begin
                            regs_r[ptr_r] <= byte_s;
                            wr_addr       <= ptr_r;
                            wr_data       <= byte_s;
                            wr_stb        <= 1'b1;
                            ptr_r         <= ptr_r + 8'd1;
                            state_r       <= ST_DATA_ACK;
                        end
                    end
`ifdef SCCB_READ_EN
                    // cnt_r counts bits already sampled by the initiator; ~cnt_r is the next bit index.
                    ST_RD: begin
                        if (byte_done_s) begin
                            state_r <= ST_RD_ACK;
                        end else if (c_fall_s) begin
                            siod_oe <= ~regs_r[ptr_r][~cnt_r];
                        end
                    end
                    ST_RD_ACK: begin
                        if (c_fall_s) begin
                            siod_oe <= 1'b0;
                        end else if (c_rise_s) begin
                            if (!d_s) begin
                                ptr_r   <= ptr_r + 8'd1;
                                state_r <= ST_RD;
                            end else begin
                                state_r <= ST_WAIT_STOP;
                            end
                        end
                    end
`endif
                    ST_WAIT_STOP: begin
                        siod_oe <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        siod_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Local host read port, one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_dout <= 8'h00;
        end else begin
            host_dout <= regs_r[host_addr];
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed self-checking bench for sccb_responder with an open-drain SIOD model.
module tb_sccb_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       siod_line;
    logic       siod_oe;
    logic       wr_stb;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [7:0] host_addr;
    logic [7:0] host_dout;

    int compared   = 0;
    int mismatched = 0;
    int stb_cnt    = 0;
    int oe_cycles  = 0;

    assign siod_line = sda_m & ~siod_oe;

    sccb_responder #(.DEVICE_ID(8'h42), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sioc      (scl),
        .siod_in   (siod_line),
        .siod_oe   (siod_oe),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .host_addr (host_addr),
        .host_dout (host_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_stb) stb_cnt++;
        if (siod_oe) oe_cycles++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCCB quarter-phase, ending on a falling clk edge.
    task automatic q();
        repeat (19) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sccb_start();
        sda_m = 1'b1; q();
        scl   = 1'b1; q();
        sda_m = 1'b0; q();
        scl   = 1'b0;
    endtask

    task automatic sccb_stop();
        sda_m = 1'b0; q();
        scl   = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; q();
            scl   = 1'b1; q();
            scl   = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; q();
        scl   = 1'b1; q();
        ack   = ~siod_line;
        scl   = 1'b0;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b, output logic oe_in_ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; q();
            scl   = 1'b1; q();
            b[i]  = siod_line;
            scl   = 1'b0;
        end
        sda_m = master_ack ? 1'b0 : 1'b1; q();
        scl   = 1'b1; q();
        oe_in_ack = siod_oe;
        scl   = 1'b0; q();
        sda_m = 1'b1;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] v);
        @(negedge clk);
        host_addr = a;
        @(posedge clk);
        #1;
        v = host_dout;
    endtask

    logic       ack;
    logic       oe_ack;
    logic [7:0] rv;
    int         stb_base;
    int         oe_base;

    initial begin
        rst_n     = 1'b0;
        scl       = 1'b1;
        sda_m     = 1'b1;
        host_addr = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_siod_oe", {15'd0, siod_oe}, 16'd0);
        chk("rst_wr_stb",  {15'd0, wr_stb},  16'd0);
        chk("rst_busy",    {15'd0, busy},    16'd0);
        chk("rst_wr_addr", {8'd0, wr_addr},  16'h00);
        chk("rst_wr_data", {8'd0, wr_data},  16'h00);
        chk("rst_host",    {8'd0, host_dout}, 16'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 3-phase write 0x42, 0x12, 0x80
        stb_base = stb_cnt;
        sccb_start();
        chk("w1_busy_start", {15'd0, busy}, 16'd1);
        send_byte(8'h42, ack); chk("w1_ack_id",   {15'd0, ack}, 16'd1);
        send_byte(8'h12, ack); chk("w1_ack_sub",  {15'd0, ack}, 16'd1);
        send_byte(8'h80, ack); chk("w1_ack_data", {15'd0, ack}, 16'd1);
        sccb_stop();
        chk("w1_busy_stop", {15'd0, busy}, 16'd0);
        chk("w1_stb_cnt", 16'(stb_cnt - stb_base), 16'd1);
        chk("w1_wr_addr", {8'd0, wr_addr}, 16'h12);
        chk("w1_wr_data", {8'd0, wr_data}, 16'h80);
        @(negedge clk);
        host_addr = 8'h12;
        #1;
        chk("w1_host_latency", {8'd0, host_dout}, 16'h00);
        @(posedge clk);
        #1;
        chk("w1_host_dout", {8'd0, host_dout}, 16'h80);

        // Wrong ID 0x60: no ack, no write
        stb_base = stb_cnt;
        oe_base  = oe_cycles;
        sccb_start();
        send_byte(8'h60, ack); chk("bad_ack_id",   {15'd0, ack}, 16'd0);
        send_byte(8'h12, ack); chk("bad_ack_sub",  {15'd0, ack}, 16'd0);
        send_byte(8'h55, ack); chk("bad_ack_data", {15'd0, ack}, 16'd0);
        chk("bad_busy_before_stop", {15'd0, busy}, 16'd1);
        sccb_stop();
        chk("bad_busy_stop", {15'd0, busy}, 16'd0);
        chk("bad_oe_cycles", 16'(oe_cycles - oe_base), 16'd0);
        chk("bad_stb_cnt", 16'(stb_cnt - stb_base), 16'd0);
        host_read(8'h12, rv); chk("bad_reg12", {8'd0, rv}, 16'h80);

        // Pointer wrap: 0x42, 0xFF, 0x11, 0x22
        stb_base = stb_cnt;
        sccb_start();
        send_byte(8'h42, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h11, ack); chk("wrap_ack_d0", {15'd0, ack}, 16'd1);
        send_byte(8'h22, ack); chk("wrap_ack_d1", {15'd0, ack}, 16'd1);
        sccb_stop();
        chk("wrap_stb_cnt", 16'(stb_cnt - stb_base), 16'd2);
        chk("wrap_wr_addr", {8'd0, wr_addr}, 16'h00);
        chk("wrap_wr_data", {8'd0, wr_data}, 16'h22);
        host_read(8'hFF, rv); chk("wrap_regFF", {8'd0, rv}, 16'h11);
        host_read(8'h00, rv); chk("wrap_reg00", {8'd0, rv}, 16'h22);

        // Write 0x76 to 0x0A, set pointer with a 2-phase write, then read
        sccb_start();
        send_byte(8'h42, ack);
        send_byte(8'h0A, ack);
        send_byte(8'h76, ack);
        sccb_stop();
        sccb_start();
        send_byte(8'h42, ack);
        send_byte(8'h0A, ack); chk("ptr_ack_sub", {15'd0, ack}, 16'd1);
        sccb_stop();
        oe_base = oe_cycles;
        sccb_start();
        send_byte(8'h43, ack);
`ifdef SCCB_READ_EN
        chk("rd_ack_id", {15'd0, ack}, 16'd1);
        read_byte(1'b0, rv, oe_ack);
        chk("rd_byte", {8'd0, rv}, 16'h76);
        chk("rd_oe_in_na", {15'd0, oe_ack}, 16'd0);
        chk("rd_busy_wait", {15'd0, busy}, 16'd1);
`else
        chk("rd_ack_id", {15'd0, ack}, 16'd0);
        chk("rd_oe_cycles", 16'(oe_cycles - oe_base), 16'd0);
`endif
        sccb_stop();
        chk("rd_busy_stop", {15'd0, busy}, 16'd0);
        chk("rd_oe_stop", {15'd0, siod_oe}, 16'd0);

        // Repeated start after 4 bits of 0xA5
        stb_base = stb_cnt;
        sccb_start();
        send_byte(8'h42, ack);
        send_byte(8'h06, ack);
        send_bits(8'hA5, 4);
        sccb_start();
        send_byte(8'h42, ack); chk("rs_ack_id", {15'd0, ack}, 16'd1);
        send_byte(8'h05, ack);
        send_byte(8'h3C, ack); chk("rs_ack_data", {15'd0, ack}, 16'd1);
        sccb_stop();
        chk("rs_stb_cnt", 16'(stb_cnt - stb_base), 16'd1);
        host_read(8'h06, rv); chk("rs_reg06", {8'd0, rv}, 16'h00);
        host_read(8'h05, rv); chk("rs_reg05", {8'd0, rv}, 16'h3C);

        // Reset during the SUB_ACK slot
        sccb_start();
        send_byte(8'h42, ack);
        send_bits(8'h33, 8);
        sda_m = 1'b1; q();
        chk("rst_ack_oe_before", {15'd0, siod_oe}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_ack_oe_async", {15'd0, siod_oe}, 16'd0);
        chk("rst_ack_busy",     {15'd0, busy},    16'd0);
        chk("rst_ack_wr_addr",  {8'd0, wr_addr},  16'h00);
        chk("rst_ack_wr_data",  {8'd0, wr_data},  16'h00);
        chk("rst_ack_host",     {8'd0, host_dout}, 16'h00);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        sccb_stop();
        host_read(8'h05, rv); chk("rst_ack_reg05", {8'd0, rv}, 16'h00);
        stb_base = stb_cnt;
        sccb_start();
        send_byte(8'h42, ack); chk("post_ack_id",   {15'd0, ack}, 16'd1);
        send_byte(8'h20, ack); chk("post_ack_sub",  {15'd0, ack}, 16'd1);
        send_byte(8'h99, ack); chk("post_ack_data", {15'd0, ack}, 16'd1);
        sccb_stop();
        chk("post_stb_cnt", 16'(stb_cnt - stb_base), 16'd1);
        chk("post_wr_addr", {8'd0, wr_addr}, 16'h20);
        chk("post_wr_data", {8'd0, wr_data}, 16'h99);
        host_read(8'h20, rv); chk("post_reg20", {8'd0, rv}, 16'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
